// File: rtl/fp_addsub_arbiter.sv
// Round-robin sharing of one pipelined FP add/sub unit between NUM_CORES cores, with per-core outstanding limits.
// Define APU_ARB_RESP_STALL_EN to add resp_ready_i backpressure through per-core response FIFOs.
module fp_addsub_arbiter #(
  parameter int NUM_CORES  = 4,
  parameter int MAX_OUTST  = 4,
  parameter int FP_WIDTH   = 32,
  parameter int RND_WIDTH  = 3,
  parameter int STAT_WIDTH = 8,
  parameter int TAG_WIDTH  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_CORES-1:0]            req_i,
  input  logic [NUM_CORES*FP_WIDTH-1:0]   opa_i,
  input  logic [NUM_CORES*FP_WIDTH-1:0]   opb_i,
  input  logic [NUM_CORES-1:0]            sub_i,
  input  logic [NUM_CORES*RND_WIDTH-1:0]  rnd_i,
`ifdef APU_ARB_RESP_STALL_EN
  input  logic [NUM_CORES-1:0]            resp_ready_i,
`endif
  output logic [NUM_CORES-1:0]            gnt_o,
  output logic [NUM_CORES-1:0]            rvalid_o,
  output logic [NUM_CORES*FP_WIDTH-1:0]   res_o,
  output logic [NUM_CORES*STAT_WIDTH-1:0] status_o,
  output logic                            unit_en_o,
  output logic [FP_WIDTH-1:0]             unit_opa_o,
  output logic [FP_WIDTH-1:0]             unit_opb_o,
  output logic                            unit_sub_o,
  output logic [RND_WIDTH-1:0]            unit_rnd_o,
  output logic [TAG_WIDTH-1:0]            unit_tag_o,
  input  logic                            unit_valid_i,
  input  logic [FP_WIDTH-1:0]             unit_res_i,
  input  logic [STAT_WIDTH-1:0]           unit_status_i,
  input  logic [TAG_WIDTH-1:0]            unit_tag_i
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  logic [TAG_WIDTH-1:0] rr_r;
  logic [CNT_W-1:0]     cnt_r [NUM_CORES];
  logic [NUM_CORES-1:0] elig_s, gnt_s, hit_s, retire_s;
  logic                 gnt_any_s;
  logic [TAG_WIDTH-1:0] gnt_idx_s;
  int                   scan_off_s, best_off_s;
  logic [FP_WIDTH-1:0]  sel_opa_s, sel_opb_s;
  logic                 sel_sub_s;
  logic [RND_WIDTH-1:0] sel_rnd_s;

  // Eligibility, round-robin pick (smallest distance from rr_r) and granted-operand mux
  always_comb begin
    best_off_s = NUM_CORES;
    scan_off_s = 0;
    gnt_idx_s  = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      elig_s[k]  = req_i[k] && (cnt_r[k] < CNT_W'(MAX_OUTST)) && !rst_i;
      scan_off_s = (k >= int'(rr_r)) ? (k - int'(rr_r)) : (k + NUM_CORES - int'(rr_r));
      if (elig_s[k] && (scan_off_s < best_off_s)) begin
        best_off_s = scan_off_s;
        gnt_idx_s  = TAG_WIDTH'(k);
      end else begin
        best_off_s = best_off_s;
      end
    end
    gnt_any_s = (best_off_s < NUM_CORES);
    sel_opa_s = '0;
    sel_opb_s = '0;
    sel_sub_s = 1'b0;
    sel_rnd_s = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      gnt_s[k]  = gnt_any_s && (gnt_idx_s == TAG_WIDTH'(k));
      sel_opa_s = sel_opa_s | ({FP_WIDTH{gnt_s[k]}} & opa_i[k*FP_WIDTH +: FP_WIDTH]);
      sel_opb_s = sel_opb_s | ({FP_WIDTH{gnt_s[k]}} & opb_i[k*FP_WIDTH +: FP_WIDTH]);
      sel_sub_s = sel_sub_s | (gnt_s[k] & sub_i[k]);
      sel_rnd_s = sel_rnd_s | ({RND_WIDTH{gnt_s[k]}} & rnd_i[k*RND_WIDTH +: RND_WIDTH]);
      hit_s[k]  = unit_valid_i && (unit_tag_i == TAG_WIDTH'(k));
    end
  end

  assign gnt_o = gnt_s;

  // Round-robin pointer and registered issue stage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_r       <= '0;
      unit_en_o  <= 1'b0;
      unit_opa_o <= '0;
      unit_opb_o <= '0;
      unit_sub_o <= 1'b0;
      unit_rnd_o <= '0;
      unit_tag_o <= '0;
    end else begin
      unit_en_o <= gnt_any_s;
      if (gnt_any_s) begin
        rr_r       <= (gnt_idx_s == TAG_WIDTH'(NUM_CORES - 1)) ? '0 : gnt_idx_s + TAG_WIDTH'(1);
        unit_opa_o <= sel_opa_s;
        unit_opb_o <= sel_opb_s;
        unit_sub_o <= sel_sub_s;
        unit_rnd_o <= sel_rnd_s;
        unit_tag_o <= gnt_idx_s;
      end
    end
  end

  // Outstanding counters: grant and retire in the same cycle cancel; never wraps
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_CORES; k++) cnt_r[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CORES; k++) begin
        if (gnt_s[k] && !retire_s[k]) begin
          cnt_r[k] <= cnt_r[k] + CNT_W'(1);
        end else if (!gnt_s[k] && retire_s[k] && (cnt_r[k] != '0)) begin
          cnt_r[k] <= cnt_r[k] - CNT_W'(1);
        end
      end
    end
  end

`ifdef APU_ARB_RESP_STALL_EN
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  logic [FP_WIDTH-1:0]   fifo_res_r [NUM_CORES][MAX_OUTST];
  logic [STAT_WIDTH-1:0] fifo_st_r  [NUM_CORES][MAX_OUTST];
  logic [PTR_W-1:0]      wr_ptr_r [NUM_CORES];
  logic [PTR_W-1:0]      rd_ptr_r [NUM_CORES];
  logic [CNT_W-1:0]      fill_r   [NUM_CORES];
  logic [NUM_CORES-1:0]  push_s, pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Push/pop strobes and registered FIFO head presented to each core
  always_comb begin
    rvalid_o = '0;
    res_o    = '0;
    status_o = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      pop_s[k]    = (fill_r[k] != '0) && resp_ready_i[k];
      push_s[k]   = hit_s[k] && ((fill_r[k] != CNT_W'(MAX_OUTST)) || pop_s[k]);
      retire_s[k] = pop_s[k];
      rvalid_o[k] = (fill_r[k] != '0);
      res_o[k*FP_WIDTH +: FP_WIDTH]       = rvalid_o[k] ? fifo_res_r[k][rd_ptr_r[k]] : '0;
      status_o[k*STAT_WIDTH +: STAT_WIDTH] = rvalid_o[k] ? fifo_st_r[k][rd_ptr_r[k]] : '0;
    end
  end

  // FIFO storage (no reset: contents are masked until written)
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NUM_CORES; k++) begin
      if (push_s[k]) begin
        fifo_res_r[k][wr_ptr_r[k]] <= unit_res_i;
        fifo_st_r[k][wr_ptr_r[k]]  <= unit_status_i;
      end
    end
  end

  // FIFO pointers and fill levels
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        wr_ptr_r[k] <= '0;
        rd_ptr_r[k] <= '0;
        fill_r[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CORES; k++) begin
        if (push_s[k]) wr_ptr_r[k] <= ptr_inc(wr_ptr_r[k]);
        if (pop_s[k])  rd_ptr_r[k] <= ptr_inc(rd_ptr_r[k]);
        if (push_s[k] && !pop_s[k]) begin
          fill_r[k] <= fill_r[k] + CNT_W'(1);
        end else if (pop_s[k] && !push_s[k]) begin
          fill_r[k] <= fill_r[k] - CNT_W'(1);
        end
      end
    end
  end
`else
  // Results pass straight through to the owning core; a return retires the op
  always_comb begin
    rvalid_o = '0;
    res_o    = '0;
    status_o = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      retire_s[k] = hit_s[k];
      rvalid_o[k] = hit_s[k];
      res_o[k*FP_WIDTH +: FP_WIDTH]       = hit_s[k] ? unit_res_i : '0;
      status_o[k*STAT_WIDTH +: STAT_WIDTH] = hit_s[k] ? unit_status_i : '0;
    end
  end
`endif

endmodule
